// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration helpers for the staggered reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } rst_seq_state_t;

  function automatic int rel_time(input int k, input int hold, input int stagger);
    return hold + k * stagger;
  endfunction

  // Counter must hold T_last+1, the value that triggers the move to RUN.
  function automatic int cnt_width(input int num_ch, input int hold, input int stagger);
    return $clog2(rel_time(num_ch - 1, hold, stagger) + 2);
  endfunction

endpackage

// File: rtl/rst_seq_gen_tick_div.sv
// Free-running divider: one-cycle strobe every DIV enabled cycles.
module tick_div #(
  parameter int DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick_o
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [W-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      tick_o  <= 1'b0;
    end else if (en) begin
      if (div_cnt == W'(DIV - 1)) begin
        div_cnt <= '0;
        tick_o  <= 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
        tick_o  <= 1'b0;
      end
    end else begin
      tick_o <= 1'b0;
    end
  end

endmodule

// File: rtl/rst_seq_gen.sv
// Staggered per-channel active-low reset release with soft re-reset and a
// periodic tick once every channel is out of reset.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYC    = 3,
  parameter int STAGGER_CYC = 1,
  parameter int TICK_DIV    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst_req,
  output logic [NUM_CH-1:0] rst_n_o,
  output logic              seq_done,
  output logic              tick_o
);

  localparam int CNT_W  = cnt_width(NUM_CH, HOLD_CYC, STAGGER_CYC);
  localparam int T_LAST = rel_time(NUM_CH - 1, HOLD_CYC, STAGGER_CYC);

  localparam logic [CNT_W-1:0] T_FIRST = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] T_DONE  = CNT_W'(T_LAST + 1);

  if (NUM_CH < 1 || HOLD_CYC < 1 || TICK_DIV < 2) begin : g_param_check
    $error("rst_seq_gen: illegal parameters NUM_CH=%0d HOLD_CYC=%0d TICK_DIV=%0d",
           NUM_CH, HOLD_CYC, TICK_DIV);
  end

  rst_seq_state_t    state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [NUM_CH-1:0] rel_hit;
  logic              restart;

  assign cnt_nxt = cnt + 1'b1;
  assign restart = rst | soft_rst_req;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_rel
    localparam logic [CNT_W-1:0] T_K = CNT_W'(rel_time(k, HOLD_CYC, STAGGER_CYC));
    assign rel_hit[k] = (cnt_nxt >= T_K);
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state    <= ST_ASSERT;
      cnt      <= '0;
      rst_n_o  <= '0;
      seq_done <= 1'b0;
    end else begin
      case (state)
        ST_ASSERT, ST_RELEASE: begin
          cnt     <= cnt_nxt;
          // OR-in keeps released channels monotonic within one sequence.
          rst_n_o <= rst_n_o | rel_hit;
          if (cnt_nxt == T_DONE) begin
            state    <= ST_RUN;
            seq_done <= 1'b1;
          end else if (cnt_nxt >= T_FIRST) begin
            state <= ST_RELEASE;
          end
        end
        ST_RUN: begin
          rst_n_o  <= '1;
          seq_done <= 1'b1;
        end
        default: begin
          state    <= ST_ASSERT;
          cnt      <= '0;
          rst_n_o  <= '0;
          seq_done <= 1'b0;
        end
      endcase
    end
  end

  tick_div #(
    .DIV(TICK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .rst   (restart),
    .en    (state == ST_RUN),
    .tick_o(tick_o)
  );

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: default and minimal parameter sets.
module tb_rst_seq_gen;

  logic       clk;
  logic       rst, soft_rst_req;
  logic [3:0] rst_n_o;
  logic       seq_done, tick_o;

  logic       rst_s, soft_s;
  logic [1:0] rst_n_s;
  logic       seq_done_s, tick_s;

  int total = 0;
  int bad   = 0;

  rst_seq_gen u_dut (
    .clk         (clk),
    .rst         (rst),
    .soft_rst_req(soft_rst_req),
    .rst_n_o     (rst_n_o),
    .seq_done    (seq_done),
    .tick_o      (tick_o)
  );

  rst_seq_gen #(
    .NUM_CH(2), .HOLD_CYC(1), .STAGGER_CYC(0), .TICK_DIV(2)
  ) u_small (
    .clk         (clk),
    .rst         (rst_s),
    .soft_rst_req(soft_s),
    .rst_n_o     (rst_n_s),
    .seq_done    (seq_done_s),
    .tick_o      (tick_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int r, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, r, obs, exp);
    end
  endtask

  // Default config: channel k released after edge 3+k, done after 7,
  // ticks after 15, 23, 31, ...
  function automatic logic [3:0] exp_rn(input int r);
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = (r >= 3 + k);
    return v;
  endfunction

  task automatic seq_check(input int r_from, input int r_to, input string tag);
    for (int r = r_from; r <= r_to; r++) begin
      step();
      chk({tag, "_rst_n"}, r, 32'(rst_n_o), 32'(exp_rn(r)));
      chk({tag, "_done"}, r, 32'(seq_done), 32'(r >= 7));
      chk({tag, "_tick"}, r, 32'(tick_o), 32'(r >= 15 && (r - 15) % 8 == 0));
    end
  endtask

  task automatic chk_zero(input string tag, input int r);
    chk({tag, "_rst_n"}, r, 32'(rst_n_o), 32'h0);
    chk({tag, "_done"}, r, 32'(seq_done), 32'h0);
    chk({tag, "_tick"}, r, 32'(tick_o), 32'h0);
  endtask

  initial begin
    rst = 1'b1; soft_rst_req = 1'b0;
    rst_s = 1'b1; soft_s = 1'b0;

    // Power-on reset, then full sequence to edge 39.
    repeat (5) step();
    chk_zero("por", 0);
    rst = 1'b0;
    seq_check(1, 39, "seq");

    // Soft request at edge 40 while in RUN.
    soft_rst_req = 1'b1;
    step();
    chk_zero("soft_run", 40);
    soft_rst_req = 1'b0;
    seq_check(1, 8, "resoft");

    // Soft request mid-sequence at edge 4.
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    seq_check(1, 3, "mid_pre");
    soft_rst_req = 1'b1;
    step();
    chk_zero("soft_mid", 4);
    soft_rst_req = 1'b0;
    seq_check(1, 7, "mid_post");

    // Both high, then soft held alone for 10 edges.
    rst = 1'b1; soft_rst_req = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_zero("soft_hold", i);
    end
    soft_rst_req = 1'b0;
    seq_check(1, 22, "after_hold");

    // rst lands on tick edge 23: reset wins.
    rst = 1'b1;
    step();
    chk_zero("rst_tick", 23);
    rst = 1'b0;

    // Minimal config: release at edge 1, done at 2, ticks after 4, 6, 8.
    chk("small_por_rst_n", 0, 32'(rst_n_s), 32'h0);
    chk("small_por_done", 0, 32'(seq_done_s), 32'h0);
    rst_s = 1'b0;
    for (int r = 1; r <= 8; r++) begin
      step();
      chk("small_rst_n", r, 32'(rst_n_s), 32'h3);
      chk("small_done", r, 32'(seq_done_s), 32'(r >= 2));
      chk("small_tick", r, 32'(tick_s), 32'(r >= 4 && r % 2 == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
